// File: rtl/sqwave_pkg.sv
// ============================================================================
// sqwave_pkg : frame constants and state encoding shared by the square-wave
//              generator and decoder.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sqwave_pkg;

    localparam int FRAME_LEN_DEF = 11;
    localparam int MARK_POS      = 9;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CAND   = 2'd1,
        LOCKED = 2'd2
    } sqwave_state_t;

endpackage

`default_nettype wire

// File: rtl/sqwave_decoder_sync2.sv
// ============================================================================
// sync2 : two-flop synchroniser, asynchronous active-low reset to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sqwave_decoder.sv
// ============================================================================
// sqwave_decoder : recovers one bit per frame from the marker-framed square
//                  wave. Optional statistics counters under SQDEC_STATS_EN.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sqwave_decoder
    import sqwave_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int MAX_MISS  = 2,
    parameter int PH_W      = $clog2(FRAME_LEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        locked,
`ifdef SQDEC_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        err
);

    localparam int              MISS_W    = $clog2(MAX_MISS + 1);
    localparam logic [PH_W-1:0] C_LAST    = PH_W'(FRAME_LEN - 1);
    localparam logic [1:0]      ST_HUNT   = HUNT;
    localparam logic [1:0]      ST_CAND   = CAND;
    localparam logic [1:0]      ST_LOCKED = LOCKED;

    logic              w_s0;
    logic              r_s1;
    logic              r_s2;
    logic              w_mk;
    logic              r_mk;
    logic              r_mk_d;
    logic              r_lvl;
    logic              w_mark;
    logic              w_last;
    logic [1:0]        r_state;
    logic [PH_W-1:0]   r_phase;
    logic [MISS_W-1:0] r_miss;
    logic              r_bit;
    logic              r_valid;
    logic              r_err;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (w_s0)
    );

    assign w_mk = (r_s1 != w_s0) && (r_s1 != r_s2);

    // Two back-to-back detections are the marker followed by a change of H
    // at the frame boundary; only the first one is a marker.
    assign w_mark = r_mk && !r_mk_d;
    assign w_last = (r_phase == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_mk   <= 1'b0;
            r_mk_d <= 1'b0;
            r_lvl  <= 1'b0;
        end else begin
            r_s1   <= w_s0;
            r_s2   <= r_s1;
            r_mk   <= w_mk;
            r_mk_d <= r_mk;
            r_lvl  <= w_s0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_phase <= '0;
            r_miss  <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_mark) begin
                        r_state <= ST_CAND;
                        r_phase <= '0;
                    end
                end
                ST_CAND: begin
                    if (w_mark) begin
                        r_phase <= '0;
                        if (w_last) begin
                            r_state <= ST_LOCKED;
                            r_miss  <= '0;
                            r_valid <= 1'b1;
                            r_bit   <= r_lvl;
                        end
                    end else if (w_last) begin
                        r_state <= ST_HUNT;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_last) begin
                        r_phase <= '0;
                        if (w_mark) begin
                            r_valid <= 1'b1;
                            r_bit   <= r_lvl;
                            r_miss  <= '0;
                        end else begin
                            r_err  <= 1'b1;
                            r_miss <= r_miss + 1'b1;
                            if (r_miss == MISS_W'(MAX_MISS - 1)) begin
                                r_state <= ST_HUNT;
                            end
                        end
                    end else begin
                        // Stray markers are flagged but never move the phase.
                        r_phase <= r_phase + 1'b1;
                        if (w_mark) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign bit_out   = r_bit;
    assign bit_valid = r_valid;
    assign err       = r_err;
    assign locked    = (r_state == ST_LOCKED);

`ifdef SQDEC_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_valid) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (r_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sqwave_decoder.sv
// ============================================================================
// tb_sqwave_decoder : directed frame-by-frame bench for sqwave_decoder.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_sqwave_decoder;

    localparam int FL = 11;
    localparam int MP = 9;

    logic clk;
    logic rst_n;
    logic sig_in;
    logic bit_out;
    logic bit_valid;
    logic locked;
    logic err;
`ifdef SQDEC_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    int n_vec;
    int n_err;
    int clash;

    sqwave_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .locked    (locked),
`ifdef SQDEC_STATS_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One generator frame: H on every slot, ~H at the marker slot and at an
    // optional extra pulse slot. Outputs are sampled 1 time unit after each edge.
    task automatic run_frame(input string tag, input logic h, input logic mark,
                             input int pulse, input int rst_slot,
                             input int exp_v, input int exp_e,
                             input logic exp_bit, input logic exp_lock);
        int   nv;
        int   ne;
        int   vs;
        logic vb;
        nv = 0;
        ne = 0;
        vs = -1;
        vb = 1'b0;
        for (int s = 0; s < FL; s++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if ((mark && s == MP) || s == pulse) sig_in = ~h;
            else                                 sig_in = h;
            @(posedge clk);
            #1;
            if (bit_valid) begin
                nv++;
                vs = s;
                vb = bit_out;
            end
            if (err) ne++;
            if (bit_valid && err) clash++;
            if (s == rst_slot) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, "/rst_outputs"}, longint'({bit_out, bit_valid, locked, err}), 0);
`ifdef SQDEC_STATS_EN
                check({tag, "/rst_frame_cnt"}, longint'(frame_cnt), 0);
                check({tag, "/rst_err_cnt"}, longint'(err_cnt), 0);
`endif
            end
        end
        check({tag, "/valid_cnt"}, nv, exp_v);
        check({tag, "/err_cnt"}, ne, exp_e);
        check({tag, "/locked"}, longint'(locked), longint'(exp_lock));
        if (exp_v > 0) begin
            check({tag, "/bit_out"}, longint'(vb), longint'(exp_bit));
            check({tag, "/valid_slot"}, vs, 2);
        end
    endtask

    initial begin
        logic saw_lk;
        logic saw_v;
        logic saw_e;
        n_vec  = 0;
        n_err  = 0;
        clash  = 0;
        rst_n  = 1'b0;
        sig_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", longint'({bit_out, bit_valid, locked, err}), 0);

        // Constant high input must never leave HUNT.
        @(negedge clk);
        rst_n  = 1'b1;
        saw_lk = 1'b0;
        saw_v  = 1'b0;
        saw_e  = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            saw_lk |= locked;
            saw_v  |= bit_valid;
            saw_e  |= err;
        end
        check("const/locked", longint'(saw_lk), 0);
        check("const/bit_valid", longint'(saw_v), 0);
        check("const/err", longint'(saw_e), 0);

        // Acquisition with H=1: lock and first bit after the 2nd marker.
        run_frame("t1_f1", 1'b1, 1'b1, -1, -1, 0, 0, 1'b0, 1'b0);
        run_frame("t1_f2", 1'b1, 1'b1, -1, -1, 0, 0, 1'b0, 1'b0);
        run_frame("t1_f3", 1'b1, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);
        run_frame("t1_f4", 1'b1, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);
        run_frame("t1_f5", 1'b1, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);

        // H switches 1->0 at the frame boundary.
        run_frame("t2_f6", 1'b0, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);
        run_frame("t2_f7", 1'b0, 1'b1, -1, -1, 1, 0, 1'b0, 1'b1);

        // One missed marker, recovery, then two consecutive misses drop lock.
        run_frame("t3_f8",  1'b0, 1'b0, -1, -1, 1, 0, 1'b0, 1'b1);
        run_frame("t3_f9",  1'b0, 1'b1, -1, -1, 0, 1, 1'b0, 1'b1);
        run_frame("t3_f10", 1'b0, 1'b1, -1, -1, 1, 0, 1'b0, 1'b1);
        run_frame("t3_f11", 1'b0, 1'b0, -1, -1, 1, 0, 1'b0, 1'b1);
        run_frame("t3_f12", 1'b0, 1'b0, -1, -1, 0, 1, 1'b0, 1'b1);
        run_frame("t3_f13", 1'b0, 1'b1, -1, -1, 0, 1, 1'b0, 1'b0);
        run_frame("t3_f14", 1'b0, 1'b1, -1, -1, 0, 0, 1'b0, 1'b0);
        run_frame("t3_f15", 1'b0, 1'b1, -1, -1, 1, 0, 1'b0, 1'b1);

        // Extra pulse at slot 4: err, cadence unchanged.
        run_frame("t4_f16", 1'b0, 1'b1, 4, -1, 1, 1, 1'b0, 1'b1);
        run_frame("t4_f17", 1'b0, 1'b1, -1, -1, 1, 0, 1'b0, 1'b1);

        // Back to H=1, then asynchronous reset mid-frame and relock.
        run_frame("t6_f18", 1'b1, 1'b1, -1, -1, 1, 0, 1'b0, 1'b1);
        run_frame("t6_f19", 1'b1, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);
`ifdef SQDEC_STATS_EN
        check("stats/frame_cnt_pre", longint'(frame_cnt), 13);
        check("stats/err_cnt_pre", longint'(err_cnt), 4);
`endif
        run_frame("t6_f20", 1'b1, 1'b1, -1, 5, 1, 0, 1'b1, 1'b0);
        run_frame("t6_f21", 1'b1, 1'b1, -1, -1, 0, 0, 1'b0, 1'b0);
        run_frame("t6_f22", 1'b1, 1'b1, -1, -1, 1, 0, 1'b1, 1'b1);
`ifdef SQDEC_STATS_EN
        check("stats/frame_cnt_post", longint'(frame_cnt), 1);
        check("stats/err_cnt_post", longint'(err_cnt), 0);
`endif

        check("valid_err_overlap", clash, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
